// File: rtl/vx_dot8_arbiter_pkg.sv
// Shared definitions for the dot8 arbiter: default pipeline depth,
// select-width helper and the signed int8 dot-product function.
package vx_dot8_arbiter_pkg;

  localparam int LATENCY_DOT8 = 2;
  localparam int DOT8_SUM_W   = 18;

  // Width of an index that can address n items, never less than one bit.
  function automatic int up_clog2(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Sum of four signed byte products; the result range -65024..65536 fits in 18 bits.
  function automatic logic signed [DOT8_SUM_W-1:0] dot8_sum(input logic [31:0] a,
                                                            input logic [31:0] b);
    logic signed [DOT8_SUM_W-1:0] sum;
    logic signed [7:0]            xa;
    logic signed [7:0]            xb;
    logic signed [15:0]           prod;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      xa   = a[8*k +: 8];
      xb   = b[8*k +: 8];
      prod = 16'(xa) * 16'(xb);
      sum  = sum + DOT8_SUM_W'(prod);
    end
    return sum;
  endfunction

endpackage

// File: rtl/vx_dot8_arbiter_pipe.sv
// Fixed-latency dot8 pipeline. Products and their sum are formed as the
// operation enters stage 0; the remaining stages only carry the result and
// sideband. The whole chain moves only when enable is high.
module vx_dot8_arbiter_pipe
  import vx_dot8_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int IDX_W     = 2,
  parameter int LATENCY   = LATENCY_DOT8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  output logic                 out_valid,
  output logic [IDX_W-1:0]     out_idx,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [XLEN-1:0]      out_data
);

  typedef struct packed {
    logic                 valid;
    logic [IDX_W-1:0]     idx;
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      data;
  } dot8_stage_t;

  dot8_stage_t                 stage_in;
  dot8_stage_t [LATENCY-1:0]   stage_d;
  dot8_stage_t [LATENCY-1:0]   stage_q;
  logic signed [DOT8_SUM_W-1:0] sum;

  // Build the stage-0 entry: dot product sign-extended to the result width.
  always_comb begin
    stage_in       = '0;
    sum            = dot8_sum(in_a, in_b);
    stage_in.valid = in_valid;
    stage_in.idx   = in_idx;
    stage_in.tag   = in_tag;
    stage_in.data  = {{(XLEN-DOT8_SUM_W){sum[DOT8_SUM_W-1]}}, sum};
  end

  // Shift every stage together when enabled, otherwise hold the whole chain.
  always_comb begin
    stage_d = stage_q;
    if (enable) begin
      stage_d[0] = stage_in;
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset discards everything in flight and zeroes the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[LATENCY-1].valid;
  assign out_idx   = stage_q[LATENCY-1].idx;
  assign out_tag   = stage_q[LATENCY-1].tag;
  assign out_data  = stage_q[LATENCY-1].data;

endmodule

// File: rtl/vx_dot8_arbiter.sv
// Round-robin arbiter sharing one dot8 pipeline among NUM_REQS requesters.
// Optional perf counters are built when VX_DOT8_PERF_EN is defined.
module vx_dot8_arbiter
  import vx_dot8_arbiter_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int LATENCY   = LATENCY_DOT8,
`ifdef VX_DOT8_PERF_EN
  parameter int PERF_W    = 32,
`endif
  localparam int REQ_SEL_W = up_clog2(NUM_REQS)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQS-1:0]                  req_valid,
  output logic [NUM_REQS-1:0]                  req_ready,
  input  logic [NUM_REQS-1:0][XLEN-1:0]        req_a,
  input  logic [NUM_REQS-1:0][XLEN-1:0]        req_b,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [XLEN-1:0]                      rsp_data,
  output logic [TAG_WIDTH-1:0]                 rsp_tag,
  output logic [REQ_SEL_W-1:0]                 rsp_idx
`ifdef VX_DOT8_PERF_EN
  ,
  output logic [NUM_REQS-1:0][PERF_W-1:0]      perf_grants,
  output logic [PERF_W-1:0]                    perf_stalls
`endif
);

  localparam int SUM_W = REQ_SEL_W + 1;

  logic [REQ_SEL_W-1:0] rr_ptr_q;
  logic [REQ_SEL_W-1:0] rr_ptr_d;
  logic [REQ_SEL_W-1:0] grant_idx;
  logic [SUM_W-1:0]     cand;
  logic [SUM_W-1:0]     next_ptr;
  logic                 any_valid;
  logic                 advance;
  logic                 fire;
  logic [31:0]          sel_a;
  logic [31:0]          sel_b;
  logic [TAG_WIDTH-1:0] sel_tag;

  // Whole datapath freezes while a response sits unaccepted at the output.
  assign advance = ~rsp_valid | rsp_ready;
  // reset_n gates acceptance so req_ready reads 0 while reset is asserted.
  assign fire    = any_valid & advance & reset_n;

  // Search from rr_ptr upward, wrapping, for the first valid requester.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQS)) cand = cand - SUM_W'(NUM_REQS);
      if (!any_valid && req_valid[cand[REQ_SEL_W-1:0]]) begin
        any_valid = 1'b1;
        grant_idx = cand[REQ_SEL_W-1:0];
      end
    end
  end

  // One-hot accept toward the winner, only when the pipeline can take it.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = fire && (grant_idx == REQ_SEL_W'(i));
    end
  end

  // Pointer moves just past the winner on a handshake, otherwise holds.
  always_comb begin
    next_ptr = {1'b0, grant_idx} + SUM_W'(1);
    if (next_ptr >= SUM_W'(NUM_REQS)) next_ptr = '0;
    rr_ptr_d = fire ? next_ptr[REQ_SEL_W-1:0] : rr_ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign sel_a   = req_a[grant_idx][31:0];
  assign sel_b   = req_b[grant_idx][31:0];
  assign sel_tag = req_tag[grant_idx];

  generate
    if (XLEN > 32) begin : g_unused_hi
      logic unused_hi;
      // Upper operand bits do not take part in the dot product.
      always_comb begin
        unused_hi = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
          unused_hi = unused_hi ^ (^req_a[i][XLEN-1:32]) ^ (^req_b[i][XLEN-1:32]);
        end
      end
    end
  endgenerate

  vx_dot8_arbiter_pipe #(
    .XLEN      (XLEN),
    .TAG_WIDTH (TAG_WIDTH),
    .IDX_W     (REQ_SEL_W),
    .LATENCY   (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (reset_n),
    .enable    (advance),
    .in_valid  (fire),
    .in_idx    (grant_idx),
    .in_tag    (sel_tag),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .out_valid (rsp_valid),
    .out_idx   (rsp_idx),
    .out_tag   (rsp_tag),
    .out_data  (rsp_data)
  );

`ifdef VX_DOT8_PERF_EN
  logic [NUM_REQS-1:0][PERF_W-1:0] perf_grants_q;
  logic [NUM_REQS-1:0][PERF_W-1:0] perf_grants_d;
  logic [PERF_W-1:0]               perf_stalls_q;
  logic [PERF_W-1:0]               perf_stalls_d;

  // Count grants per requester and cycles where someone waited without a handshake.
  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_stalls_d = perf_stalls_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (req_ready[i]) perf_grants_d[i] = perf_grants_q[i] + PERF_W'(1);
    end
    if ((|req_valid) && !fire) perf_stalls_d = perf_stalls_q + PERF_W'(1);
  end

  // Perf counter registers; they wrap naturally at the counter width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
